pe_mac_param: RTL and testbench
===============================

// Module: pe_mac_param
// PURPOSE
//  Parametrised systolic-array processing element; successor to the fixed 8-bit PE.
//  - Signed MAC with a wide accumulator, valid-qualified operands and forwarding of a/b to neighbours.
//  - Output-stationary result drain over a c_in -> c_out shift chain.
//  - Optional saturating narrowing of the result.
//  - Tiles an N x N array; a flows east, b flows south, results drain along rows.
// PARAMETERS
//  DW     8   operand width (a, b), signed two's complement
//  ACC_W  24  accumulator width; must satisfy ACC_W >= 2*DW
//  OW     8   result width on c_in/c_out
//  SHIFT  0   arithmetic right shift applied to acc before narrowing (0..ACC_W-OW)
// PORTS
//  clk          in   1      clock, all state rises on posedge
//  rst          in   1      synchronous reset, active-low
//  clear        in   1      zero accumulator, mac_cnt and ovf
//  a_in         in   DW     operand A from west
//  a_vld_in     in   1      a_in valid
//  b_in         in   DW     operand B from north
//  b_vld_in     in   1      b_in valid
//  a_out        out  DW     registered a_in to east
//  a_vld_out    out  1      registered a_vld_in
//  b_out        out  DW     registered b_in to south
//  b_vld_out    out  1      registered b_vld_in
//  load         in   1      capture narrowed acc into c_out
//  shift        in   1      shift c_in into c_out (drain chain)
//  c_in         in   OW     result from upstream PE in drain chain
//  c_vld_in     in   1      c_in valid
//  c_out        out  OW     result register
//  c_vld_out    out  1      c_out valid
//  mac_cnt      out  16     MACs performed since clear/reset, saturates at 16'hFFFF
//  ovf          out  1      sticky: a narrowing under load clipped/wrapped
// BEHAVIOUR
//  - Reset (rst==0 at posedge): acc, a_out, b_out, c_out, mac_cnt = 0; all *_vld_out = 0; ovf = 0.
//    Reset dominates every other input.
//  - Forwarding: a_out/a_vld_out and b_out/b_vld_out lag their inputs by 1 cycle.
//    Forwarding is unconditional; data flows even when the partner operand is invalid.
//  - fire = a_vld_in & b_vld_in.
//  - On fire: acc <= acc + sext(a_in*b_in); mac_cnt++. The product is full 2*DW signed.
//  - Accumulator addition wraps modulo 2^ACC_W; there is no accumulator saturation.
//  - clear without fire: acc <= 0, mac_cnt <= 0, ovf <= 0.
//  - clear with fire: acc <= product, mac_cnt <= 1 (clear-then-accumulate, no bubble).
//  - Result path: nar = narrow(acc >>> SHIFT) from the acc value BEFORE this cycle's update.
//  - Load and shift priority:
//    - load: c_out <= nar, c_vld_out <= 1; ovf |= (nar != full value).
//    - shift (no load): c_out <= c_in, c_vld_out <= c_vld_in.
//    - load & shift: load wins; c_in is dropped.
//    - neither: c_out and c_vld_out hold.
//  - load and clear together: load captures the pre-clear acc; the acc then clears.
//  - Latency: operand-in to acc update 1 cycle; acc to c_out 1 cycle after load.
// CONFIGURATION
//  PE_SAT_EN defined:
//    - narrow() clamps to [-2^(OW-1), 2^(OW-1)-1].
//    - ovf sets when a clamp occurs.
//  PE_SAT_EN undefined:
//    - narrow() keeps the low OW bits (wraps).
//    - ovf sets when the discarded upper bits are not the sign extension of the kept bits.
// STRUCTURE
//  tpu_pe_pkg:
//    - function sat_narrow (ACC_W -> OW), shared with the array output stage.
//    - localparam MAC_CNT_W = 16.
//  Sub-module pe_narrow: combinational shift+narrow+ovf detect, PE_SAT_EN selectable.
//    Reused by the array edge accumulators.
// TESTING (DW=8, ACC_W=24, OW=8, SHIFT=0)
//  1. Hold rst=0 for 2 cycles with all inputs high -> every output 0, all *_vld_out 0.
//  2. a=3, b=4, both valid for 3 cycles, then load -> c_out=36 (0x24), c_vld_out=1, mac_cnt=3, ovf=0.
//  3. clear, then a=-5, b=7 once, then load -> c_out=0xDD (-35), mac_cnt=1.
//  4. Overflow: a=127, b=127 twice (acc=32258), then load
//     -> with PE_SAT_EN: c_out=0x7F, ovf=1; without: c_out=0x02, ovf=1.
//  5. Simultaneous events:
//     - acc=10, then clear with a=2, b=3 valid -> acc=6, mac_cnt=1.
//     - a_vld_in=1, b_vld_in=0 -> acc unchanged, a_out=a_in next cycle.
//  6. Drain chain:
//     - c_in=0x55, c_vld_in=1, shift=1 -> c_out=0x55 next cycle.
//     - load & shift with acc=9 -> c_out=0x09.
//     - rst mid-drain -> c_out=0, c_vld_out=0.

Source files
------------

// File: rtl/tpu_pe_pkg.sv
// ============================================================================
// tpu_pe_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the systolic-array processing elements and the
// array output stage.
//   MAC_CNT_W   width of the per-PE MAC counter
//   NARROW_W    widest accumulator the shared narrowing helper accepts
//   sat_narrow  clamps a signed value to the signed range of a given width
// ============================================================================
package tpu_pe_pkg;

    localparam int MAC_CNT_W = 16;
    localparam int NARROW_W  = 64;

    // Clamp a sign-extended value into [-2^(ow-1), 2^(ow-1)-1]. The result
    // is returned at full width; callers keep the low ow bits.
    function automatic logic signed [NARROW_W-1:0] sat_narrow(
        input logic signed [NARROW_W-1:0] val,
        input int unsigned                ow
    );
        logic signed [NARROW_W-1:0] hi;
        logic signed [NARROW_W-1:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (val > hi) begin
            return hi;
        end else if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage : tpu_pe_pkg

// File: rtl/pe_narrow.sv
// ============================================================================
// pe_narrow
// ----------------------------------------------------------------------------
// Combinational result narrowing: arithmetic right shift by SHIFT, then
// reduction from ACC_W to OW bits, plus detection of information loss.
// Reused by the array edge accumulators.
//
// Build option PE_SAT_EN:
//   defined   - result clamps to the signed OW range; clip_o flags a clamp
//   undefined - result keeps the low OW bits (wraps); clip_o flags that the
//               discarded upper bits were not a sign extension
//
// Ports
//   acc_i   in   ACC_W  accumulator value (signed two's complement)
//   nar_o   out  OW     narrowed result
//   clip_o  out  1      narrowed result differs from the shifted value
// ============================================================================
module pe_narrow
    import tpu_pe_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int OW    = 8,
    parameter int SHIFT = 0
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [OW-1:0]    nar_o,
    output logic             clip_o
);

    logic signed [ACC_W-1:0] shifted;

    assign shifted = $signed(acc_i) >>> SHIFT;

`ifdef PE_SAT_EN
    logic signed [NARROW_W-1:0] shifted_ext;
    logic signed [NARROW_W-1:0] clamped;

    // NOTE: every signal driven from always_comb gets a value on every path
    // (here by straight-line assignment); a missing path infers a latch.
    always_comb begin
        shifted_ext = NARROW_W'(shifted);
        clamped     = sat_narrow(shifted_ext, OW);
        nar_o       = clamped[OW-1:0];
        clip_o      = (clamped != shifted_ext);
    end
`else
    logic signed [ACC_W-1:0] rebuilt;

    always_comb begin
        nar_o   = shifted[OW-1:0];
        // Sign-extending the kept bits back out reproduces the shifted value
        // only when nothing significant was discarded.
        rebuilt = ACC_W'($signed(nar_o));
        clip_o  = (rebuilt != shifted);
    end
`endif

endmodule : pe_narrow

// File: rtl/pe_mac_param.sv
// ============================================================================
// pe_mac_param
// ----------------------------------------------------------------------------
// Parametrised output-stationary systolic-array processing element.
// Signed MAC into a wide wrapping accumulator, one-cycle forwarding of the
// operands to the east/south neighbours, and a c_in -> c_out drain chain
// through which narrowed results leave the array row.
// Build option PE_SAT_EN (see pe_narrow) selects saturating narrowing.
//
// Ports
//   clk        in   1          clock, rising edge
//   rst        in   1          synchronous reset, active-low
//   clear      in   1          zero accumulator, mac_cnt and ovf
//   a_in       in   DW         operand A from west (signed)
//   a_vld_in   in   1          a_in valid
//   b_in       in   DW         operand B from north (signed)
//   b_vld_in   in   1          b_in valid
//   a_out      out  DW         a_in delayed one cycle, to east
//   a_vld_out  out  1          a_vld_in delayed one cycle
//   b_out      out  DW         b_in delayed one cycle, to south
//   b_vld_out  out  1          b_vld_in delayed one cycle
//   load       in   1          capture narrowed accumulator into c_out
//   shift      in   1          move c_in into c_out
//   c_in       in   OW         result from upstream PE
//   c_vld_in   in   1          c_in valid
//   c_out      out  OW         result register
//   c_vld_out  out  1          c_out valid
//   mac_cnt    out  16         MACs since clear/reset, saturating
//   ovf        out  1          sticky narrowing-loss flag
// ============================================================================
module pe_mac_param
    import tpu_pe_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = 24,
    parameter int OW    = 8,
    parameter int SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [DW-1:0]        a_in,
    input  logic                 a_vld_in,
    input  logic [DW-1:0]        b_in,
    input  logic                 b_vld_in,
    output logic [DW-1:0]        a_out,
    output logic                 a_vld_out,
    output logic [DW-1:0]        b_out,
    output logic                 b_vld_out,
    input  logic                 load,
    input  logic                 shift,
    input  logic [OW-1:0]        c_in,
    input  logic                 c_vld_in,
    output logic [OW-1:0]        c_out,
    output logic                 c_vld_out,
    output logic [MAC_CNT_W-1:0] mac_cnt,
    output logic                 ovf
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]     acc_q,     acc_d;
    logic [MAC_CNT_W-1:0] mac_cnt_q, mac_cnt_d;
    logic                 ovf_q,     ovf_d;
    logic [OW-1:0]        c_q,       c_d;
    logic                 c_vld_q,   c_vld_d;
    logic [DW-1:0]        a_q, b_q;
    logic                 a_vld_q, b_vld_q;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic                    fire;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0]        acc_base;
    logic [OW-1:0]           nar;
    logic                    clip;

    assign fire     = a_vld_in & b_vld_in;
    assign prod     = $signed(a_in) * $signed(b_in);
    assign prod_ext = ACC_W'(prod);

    // Narrowing always looks at the registered acc, i.e. the value before
    // this cycle's MAC or clear takes effect.
    pe_narrow #(
        .ACC_W (ACC_W),
        .OW    (OW),
        .SHIFT (SHIFT)
    ) u_narrow (
        .acc_i  (acc_q),
        .nar_o  (nar),
        .clip_o (clip)
    );

    always_comb begin
        // clear with fire restarts from the new product, no bubble.
        acc_base  = clear ? '0 : acc_q;
        acc_d     = acc_base;
        mac_cnt_d = clear ? '0 : mac_cnt_q;
        if (fire) begin
            acc_d = acc_base + prod_ext;
            if (mac_cnt_d != '1) begin
                mac_cnt_d = mac_cnt_d + MAC_CNT_W'(1);
            end
        end

        // A load coinciding with clear still reports its own clip, so the
        // loss on the value just captured is never hidden.
        ovf_d = (clear ? 1'b0 : ovf_q) | (load & clip);

        c_d     = c_q;
        c_vld_d = c_vld_q;
        if (load) begin
            c_d     = nar;
            c_vld_d = 1'b1;
        end else if (shift) begin
            c_d     = c_in;
            c_vld_d = c_vld_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q     <= '0;
            mac_cnt_q <= '0;
            ovf_q     <= 1'b0;
            c_q       <= '0;
            c_vld_q   <= 1'b0;
            a_q       <= '0;
            a_vld_q   <= 1'b0;
            b_q       <= '0;
            b_vld_q   <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            mac_cnt_q <= mac_cnt_d;
            ovf_q     <= ovf_d;
            c_q       <= c_d;
            c_vld_q   <= c_vld_d;
            // Forwarding is unconditional so the wavefront keeps moving even
            // when the partner operand is invalid.
            a_q       <= a_in;
            a_vld_q   <= a_vld_in;
            b_q       <= b_in;
            b_vld_q   <= b_vld_in;
        end
    end

    assign a_out     = a_q;
    assign a_vld_out = a_vld_q;
    assign b_out     = b_q;
    assign b_vld_out = b_vld_q;
    assign c_out     = c_q;
    assign c_vld_out = c_vld_q;
    assign mac_cnt   = mac_cnt_q;
    assign ovf       = ovf_q;

endmodule : pe_mac_param

// File: tb/tb_pe_mac_param.sv
// ============================================================================
// tb_pe_mac_param
// ----------------------------------------------------------------------------
// Directed bench for pe_mac_param at DW=8, ACC_W=24, OW=8, SHIFT=0.
// Expected values are hand-computed; PE_SAT_EN selects the clamp/wrap
// expectation for the overflow case.
// ============================================================================
`timescale 1ns/1ps
module tb_pe_mac_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [7:0]  a_in, b_in;
    logic        a_vld_in, b_vld_in;
    logic [7:0]  a_out, b_out;
    logic        a_vld_out, b_vld_out;
    logic        load, shift;
    logic [7:0]  c_in;
    logic        c_vld_in;
    logic [7:0]  c_out;
    logic        c_vld_out;
    logic [15:0] mac_cnt;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pe_mac_param #(
        .DW    (8),
        .ACC_W (24),
        .OW    (8),
        .SHIFT (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .a_in      (a_in),
        .a_vld_in  (a_vld_in),
        .b_in      (b_in),
        .b_vld_in  (b_vld_in),
        .a_out     (a_out),
        .a_vld_out (a_vld_out),
        .b_out     (b_out),
        .b_vld_out (b_vld_out),
        .load      (load),
        .shift     (shift),
        .c_in      (c_in),
        .c_vld_in  (c_vld_in),
        .c_out     (c_out),
        .c_vld_out (c_vld_out),
        .mac_cnt   (mac_cnt),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after
    // the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear    = 1'b0;
        a_in     = 8'h00;
        b_in     = 8'h00;
        a_vld_in = 1'b0;
        b_vld_in = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        c_in     = 8'h00;
        c_vld_in = 1'b0;
    endtask

    task automatic mac(input logic [7:0] a, input logic [7:0] b);
        a_in = a; b_in = b; a_vld_in = 1'b1; b_vld_in = 1'b1;
    endtask

    initial begin
        // 1. Reset with every input high
        rst = 1'b0;
        clear = 1'b1; a_in = 8'hFF; b_in = 8'hFF; a_vld_in = 1'b1; b_vld_in = 1'b1;
        load = 1'b1; shift = 1'b1; c_in = 8'hFF; c_vld_in = 1'b1;
        tick(); tick();
        check("rst_a_out",     a_out,     0);
        check("rst_a_vld",     a_vld_out, 0);
        check("rst_b_out",     b_out,     0);
        check("rst_b_vld",     b_vld_out, 0);
        check("rst_c_out",     c_out,     0);
        check("rst_c_vld",     c_vld_out, 0);
        check("rst_mac_cnt",   mac_cnt,   0);
        check("rst_ovf",       ovf,       0);
        rst = 1'b1;
        idle_inputs();
        tick();

        // 2. 3*4 accumulated three times
        mac(8'd3, 8'd4);
        tick();
        check("fwd_a_out",     a_out,     8'd3);
        check("fwd_a_vld",     a_vld_out, 1);
        check("fwd_b_out",     b_out,     8'd4);
        tick(); tick();
        idle_inputs(); load = 1'b1;
        tick();
        check("t2_c_out",      c_out,     8'h24);
        check("t2_c_vld",      c_vld_out, 1);
        check("t2_mac_cnt",    mac_cnt,   3);
        check("t2_ovf",        ovf,       0);

        // 3. clear, then -5*7
        idle_inputs(); clear = 1'b1;
        tick();
        check("t3_clr_cnt",    mac_cnt,   0);
        idle_inputs(); mac(8'hFB, 8'd7);
        tick();
        idle_inputs(); load = 1'b1;
        tick();
        check("t3_c_out",      c_out,     8'hDD);
        check("t3_mac_cnt",    mac_cnt,   1);
        check("t3_ovf",        ovf,       0);

        // 4. Overflow: 127*127 twice -> 32258 = 0x007E02
        idle_inputs(); clear = 1'b1;
        tick();
        idle_inputs(); mac(8'd127, 8'd127);
        tick(); tick();
        idle_inputs(); load = 1'b1;
        tick();
`ifdef PE_SAT_EN
        check("t4_c_out",      c_out,     8'h7F);
`else
        check("t4_c_out",      c_out,     8'h02);
`endif
        check("t4_ovf",        ovf,       1);
        check("t4_mac_cnt",    mac_cnt,   2);
        idle_inputs();
        tick();
        check("t4_ovf_sticky", ovf,       1);

        // 5a. acc=10, then clear with 2*3 firing -> acc=6, mac_cnt=1
        idle_inputs(); clear = 1'b1;
        tick();
        check("t5_ovf_clr",    ovf,       0);
        idle_inputs(); mac(8'd2, 8'd5);
        tick();
        idle_inputs(); clear = 1'b1; mac(8'd2, 8'd3);
        tick();
        check("t5_clrfire_cnt", mac_cnt,  1);
        idle_inputs(); load = 1'b1;
        tick();
        check("t5_clrfire_acc", c_out,    8'd6);

        // 5b. only A valid: no MAC, forwarding still runs
        idle_inputs(); a_in = 8'h11; a_vld_in = 1'b1; b_in = 8'h22;
        tick();
        check("t5_half_a_out", a_out,     8'h11);
        check("t5_half_a_vld", a_vld_out, 1);
        check("t5_half_b_out", b_out,     8'h22);
        check("t5_half_b_vld", b_vld_out, 0);
        check("t5_half_cnt",   mac_cnt,   1);
        idle_inputs(); load = 1'b1;
        tick();
        check("t5_half_acc",   c_out,     8'd6);

        // 5c. load with clear captures pre-clear acc, then acc is zero
        idle_inputs(); load = 1'b1; clear = 1'b1;
        tick();
        check("t5_ldclr_c",    c_out,     8'd6);
        check("t5_ldclr_cnt",  mac_cnt,   0);
        idle_inputs(); load = 1'b1;
        tick();
        check("t5_ldclr_zero", c_out,     8'd0);

        // 6. Drain chain
        idle_inputs(); shift = 1'b1; c_in = 8'h55; c_vld_in = 1'b1;
        tick();
        check("t6_shift_c",    c_out,     8'h55);
        check("t6_shift_vld",  c_vld_out, 1);
        idle_inputs(); shift = 1'b1; c_in = 8'h33; c_vld_in = 1'b0;
        tick();
        check("t6_shinv_c",    c_out,     8'h33);
        check("t6_shinv_vld",  c_vld_out, 0);
        idle_inputs(); c_in = 8'h77; c_vld_in = 1'b1;
        tick();
        check("t6_hold_c",     c_out,     8'h33);
        check("t6_hold_vld",   c_vld_out, 0);

        // load & shift with acc=9: load wins
        idle_inputs(); mac(8'd3, 8'd3);
        tick();
        idle_inputs(); load = 1'b1; shift = 1'b1; c_in = 8'hAA; c_vld_in = 1'b0;
        tick();
        check("t6_ldsh_c",     c_out,     8'h09);
        check("t6_ldsh_vld",   c_vld_out, 1);

        // reset mid-drain
        idle_inputs(); shift = 1'b1; c_in = 8'h12; c_vld_in = 1'b1;
        tick();
        check("t6_pre_rst_c",  c_out,     8'h12);
        rst = 1'b0;
        tick();
        check("t6_rst_c",      c_out,     0);
        check("t6_rst_vld",    c_vld_out, 0);
        check("t6_rst_cnt",    mac_cnt,   0);
        rst = 1'b1;
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pe_mac_param
